// File: rtl/spi_master_if.sv
// spi_master_if: request/response bundle plus SPI pins for spi_master.
// ovr is present only when SPI_MASTER_OVR_EN is defined.
interface spi_master_if;
  logic        start;
  logic        rw;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        ssn;
  logic        mosi;
  logic        miso;
`ifdef SPI_MASTER_OVR_EN
  logic        ovr;
`endif

  modport master (
    input  start, rw, addr, wdata, miso,
    output rdata, busy, done, sclk, ssn, mosi
`ifdef SPI_MASTER_OVR_EN
    , output ovr
`endif
  );

  modport slave (
    output start, rw, addr, wdata, miso,
    input  rdata, busy, done, sclk, ssn, mosi
`ifdef SPI_MASTER_OVR_EN
    , input ovr
`endif
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: 32-bit mode-0 SPI frame engine (addr, cmd, 16-bit data).
// Optional sticky overrun flag ovr when SPI_MASTER_OVR_EN is defined.
module spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int SETUP_CYC = 2,
  parameter int IDLE_GAP  = 4
) (
  input logic clk,
  input logic rst,
  spi_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] SU_M1  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] GAP_M1 = 8'(IDLE_GAP - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [31:0] sh, sh_n;
  logic [15:0] rx, rx_n;
  logic [15:0] rdata_q, rdata_n;
  logic        rw_q, rw_n;
  logic        sclk_q, sclk_n;
  logic        ssn_q, ssn_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic [31:0] frame;

  assign frame = {bus.addr, bus.rw, 7'b0,
                  bus.rw ? 16'h0000 : bus.wdata};

  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sclk  = sclk_q;
  assign bus.ssn   = ssn_q;
  assign bus.mosi  = sh[31];

  // State and output registers; every pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      rx      <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      sclk_q  <= 1'b0;
      ssn_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      rx      <= rx_n;
      rdata_q <= rdata_n;
      rw_q    <= rw_n;
      sclk_q  <= sclk_n;
      ssn_q   <= ssn_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    rx_n      = rx;
    rdata_n   = rdata_q;
    rw_n      = rw_q;
    sclk_n    = sclk_q;
    ssn_n     = ssn_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n   = SETUP;
          cnt_n     = '0;
          bit_cnt_n = '0;
          sh_n      = frame;
          rw_n      = bus.rw;
          ssn_n     = 1'b0;
          busy_n    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == SU_M1) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt == DIV_M1) begin
          cnt_n  = '0;
          sclk_n = !sclk_q;
          if (!sclk_q) begin
            rx_n = {rx[14:0], bus.miso};
          end else begin
            bit_cnt_n = bit_cnt + 6'd1;
            sh_n      = {sh[30:0], 1'b0};
            if (bit_cnt == 6'd31) begin
              state_n = HOLD;
            end
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      HOLD: begin
        if (cnt == SU_M1) begin
          state_n = GAP;
          cnt_n   = '0;
          ssn_n   = 1'b1;
          sh_n    = '0;
          done_n  = 1'b1;
          if (rw_q) begin
            rdata_n = rx;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_M1) begin
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

`ifdef SPI_MASTER_OVR_EN
  logic ovr_q;
  assign bus.ovr = ovr_q;

  // Sticky flag for requests dropped because a frame was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (bus.start && busy_q) begin
      ovr_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized frames against a frame-level reference model.
// Covers two parameter sets; checks ovr when SPI_MASTER_OVR_EN is defined.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int DIV1 = 4;
  localparam int SC1  = 2;
  localparam int IG1  = 4;
  localparam int DIV2 = 2;
  localparam int SC2  = 1;
  localparam int IG2  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_if bus1();
  spi_master_if bus2();

  spi_master u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  spi_master #(
    .CLK_DIV   (DIV2),
    .SETUP_CYC (SC2),
    .IDLE_GAP  (IG2)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic        sel;
  logic        start;
  logic        rw;
  logic        miso;
  logic [7:0]  addr;
  logic [15:0] wdata;

  assign bus1.start = start & ~sel;
  assign bus2.start = start & sel;
  assign bus1.rw    = rw;
  assign bus2.rw    = rw;
  assign bus1.addr  = addr;
  assign bus2.addr  = addr;
  assign bus1.wdata = wdata;
  assign bus2.wdata = wdata;
  assign bus1.miso  = miso;
  assign bus2.miso  = miso;

  logic        m_sclk, m_ssn, m_mosi, m_busy, m_done;
  logic [15:0] m_rdata;
  assign m_sclk  = sel ? bus2.sclk  : bus1.sclk;
  assign m_ssn   = sel ? bus2.ssn   : bus1.ssn;
  assign m_mosi  = sel ? bus2.mosi  : bus1.mosi;
  assign m_busy  = sel ? bus2.busy  : bus1.busy;
  assign m_done  = sel ? bus2.done  : bus1.done;
  assign m_rdata = sel ? bus2.rdata : bus1.rdata;

  int          n_vec;
  int          n_err;
  bit          noise_seen;
  logic [15:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One frame: drive, watch pins, serve miso, compare with the model.
  task automatic run_txn(
    input logic        rw_i,
    input logic [7:0]  a_i,
    input logic [15:0] wd_i,
    input logic [15:0] mw_i,
    input bit          chain_i,
    input bit          pre_i,
    input logic        nrw,
    input logic [7:0]  na,
    input logic [15:0] nwd,
    input bit          noise_i
  );
    int          div, sc, ig, low, rises, falls;
    int          dcnt, dcyc, gap, cyc_fin;
    logic [31:0] cap, stream, expw;
    logic [15:0] rd_done;
    bit          prev, fin;
    div     = sel ? DIV2 : DIV1;
    sc      = sel ? SC2 : SC1;
    ig      = sel ? IG2 : IG1;
    stream  = {16'($urandom), mw_i};
    expw    = {a_i, rw_i, 7'b0, rw_i ? 16'h0000 : wd_i};
    low     = 0;
    rises   = 0;
    falls   = 0;
    dcnt    = 0;
    dcyc    = -1;
    gap     = 0;
    cyc_fin = -1;
    cap     = '0;
    rd_done = '0;
    prev    = 1'b0;
    fin     = 1'b0;
    miso    = stream[31];
    if (!pre_i) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      rw    = rw_i;
      addr  = a_i;
      wdata = wd_i;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int cyc = 1; cyc < 1000 && !fin; cyc++) begin
      if (!(pre_i && cyc == 1)) @(negedge clk);
      if (noise_i && dcnt == 0) begin
        start = (cyc >= 20 && cyc < 200) && ($urandom_range(7) == 0);
        if (start) begin
          noise_seen = 1'b1;
          rw   = 1'($urandom);
          addr = 8'($urandom);
        end
      end
      if (!m_ssn && dcnt == 0) low++;
      if (m_sclk && !prev) begin
        rises++;
        cap = {cap[30:0], m_mosi};
      end
      if (!m_sclk && prev) begin
        falls++;
        if (falls < 32) miso = stream[31-falls];
      end
      prev = m_sclk;
      if (m_done) begin
        dcnt++;
        if (dcnt == 1) begin
          dcyc    = cyc;
          rd_done = m_rdata;
        end
      end
      if (dcnt > 0) begin
        if (chain_i) begin
          if (m_ssn) begin
            gap++;
            start = 1'b1;
            rw    = nrw;
            addr  = na;
            wdata = nwd;
          end else begin
            fin   = 1'b1;
            start = 1'b0;
          end
        end else if (!m_busy) begin
          fin     = 1'b1;
          cyc_fin = cyc;
        end
      end
    end
    start = 1'b0;
    if (!fin) begin
      chk("txn_timeout", 32'd0, 32'd1);
    end else begin
      if (rw_i) exp_rd[sel] = mw_i;
      chk("mosi_word", cap, expw);
      chk("sclk_rises", 32'(rises), 32'd32);
      chk("ssn_low", 32'(low), 32'(2*sc + 64*div));
      chk("done_cyc", 32'(dcyc), 32'(1 + 2*sc + 64*div));
      chk("done_width", 32'(dcnt), 32'd1);
      chk("rdata", 32'(rd_done), 32'(exp_rd[sel]));
      if (chain_i) chk("gap", 32'(gap), 32'(ig + 1));
      else chk("idle_cyc", 32'(cyc_fin), 32'(dcyc + ig));
    end
  endtask

  // Reset in the cycle of the 10th sclk rise, with start held alongside.
  task automatic rst_abort();
    int r;
    bit prev;
    r    = 0;
    prev = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    rw    = 1'b0;
    addr  = 8'h5A;
    wdata = 16'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 400 && r < 10; c++) begin
      @(negedge clk);
      if (m_sclk && !prev) r++;
      prev = m_sclk;
    end
    chk("rst_reach", 32'(r), 32'd10);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_ssn", 32'(m_ssn), 32'd1);
    chk("abort_sclk", 32'(m_sclk), 32'd0);
    chk("abort_busy", 32'(m_busy), 32'd0);
    chk("abort_done", 32'(m_done), 32'd0);
    chk("abort_mosi", 32'(m_mosi), 32'd0);
    chk("abort_rdata", 32'(m_rdata), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
    @(negedge clk);
    chk("rst_prio_busy", 32'(m_busy), 32'd0);
    chk("rst_prio_ssn", 32'(m_ssn), 32'd1);
`ifdef SPI_MASTER_OVR_EN
    chk("ovr_cleared", 32'(bus1.ovr), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic        nrw;
    logic [7:0]  na;
    logic [15:0] nwd;
    n_vec      = 0;
    n_err      = 0;
    noise_seen = 1'b0;
    sel        = 1'b0;
    start      = 1'b0;
    rw         = 1'b0;
    addr       = '0;
    wdata      = '0;
    miso       = 1'b0;
    exp_rd[0]  = 16'h0000;
    exp_rd[1]  = 16'h0000;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ssn", 32'(bus1.ssn), 32'd1);
    chk("rst_sclk", 32'(bus1.sclk), 32'd0);
    chk("rst_mosi", 32'(bus1.mosi), 32'd0);
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_done", 32'(bus1.done), 32'd0);
    chk("rst_rdata", 32'(bus1.rdata), 32'd0);
    chk("rst_ssn2", 32'(bus2.ssn), 32'd1);
`ifdef SPI_MASTER_OVR_EN
    chk("rst_ovr", 32'(bus1.ovr), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_txn(1'b1, 8'h12, 16'h0000, 16'hBEEF, 0, 0, 1'b0, 8'h0, 16'h0, 0);
    run_txn(1'b0, 8'h3C, 16'hA55A, 16'h1234, 0, 0, 1'b0, 8'h0, 16'h0, 0);

    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
              0, 0, 1'b0, 8'h0, 16'h0,
              (i == 0) || ($urandom_range(1) == 1));
    end
`ifdef SPI_MASTER_OVR_EN
    chk("ovr_sticky", 32'(bus1.ovr), 32'(noise_seen));
`endif

    nrw = 1'($urandom);
    na  = 8'($urandom);
    nwd = 16'($urandom);
    run_txn(1'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
            1, 0, nrw, na, nwd, 0);
    run_txn(nrw, na, nwd, 16'($urandom), 0, 1, 1'b0, 8'h0, 16'h0, 0);

    rst_abort();
    run_txn(1'b0, 8'($urandom), 16'($urandom), 16'($urandom),
            0, 0, 1'b0, 8'h0, 16'h0, 0);

    @(posedge clk);
    #1;
    sel = 1'b1;
    run_txn(1'b1, 8'($urandom), 16'($urandom), 16'($urandom),
            0, 0, 1'b0, 8'h0, 16'h0, 0);
    run_txn(1'b0, 8'($urandom), 16'($urandom), 16'($urandom),
            0, 0, 1'b0, 8'h0, 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
